// File: rtl/vga_capture.sv
// Recovers VGA line/frame timing from sync edges, measures it, and emits active pixels with x/y once stable.
// Latency: 2 clk from input sample to pix_* (input register, then output register).
// Backpressure: none; streaming sink, every sample is consumed on the clock it arrives.
module vga_capture #(
    parameter int   H_START     = 144,
    parameter int   H_ACTIVE    = 640,
    parameter int   V_START     = 35,
    parameter int   V_ACTIVE    = 480,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [2:0]  red_in,
    input  logic [2:0]  green_in,
    input  logic [1:0]  blue_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [7:0]  pix_rgb,
    output logic        frame_start,
    output logic [11:0] line_period,
    output logic [10:0] frame_lines,
    output logic        locked
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    logic          hs_s1, vs_s1, hs_d, vs_d;
    logic [7:0]    rgb_s1;
    logic [11:0]   h_cnt, h_inc, h_cur;
    logic [10:0]   v_cnt, v_inc, v_cur;
    logic          hedge, vedge, h_sat, h_act, v_act, pix_ok;
    logic          line_bad, frame_bad, chk_line_bad;
    state_t        state, state_nx;
    logic [11:0]   ref_line, ref_line_nx;
    logic [10:0]   ref_frame, ref_frame_nx;
    logic          rl_ok, rl_ok_nx, rf_ok, rf_ok_nx, line_mis, line_mis_nx;
    logic [GW-1:0] good_cnt, good_nx;

    // Stage 1 captures syncs and colour together; the delayed copy of the syncs feeds edge detection.
    // Syncs reset to their idle level so a stream starting on a sync pulse still yields an edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hs_s1  <= ~SYNC_POL;
            vs_s1  <= ~SYNC_POL;
            hs_d   <= ~SYNC_POL;
            vs_d   <= ~SYNC_POL;
            rgb_s1 <= '0;
        end else begin
            hs_s1  <= hsync_in;
            vs_s1  <= vsync_in;
            hs_d   <= hs_s1;
            vs_d   <= vs_s1;
            rgb_s1 <= {red_in, green_in, blue_in};
        end
    end

    assign hedge = (hs_s1 == SYNC_POL) && (hs_d != SYNC_POL);
    assign vedge = (vs_s1 == SYNC_POL) && (vs_d != SYNC_POL);

    // Saturating increments double as the period/line measurements taken at an edge.
    assign h_inc = (h_cnt == '1) ? h_cnt : h_cnt + 12'd1;
    assign v_inc = (v_cnt == '1) ? v_cnt : v_cnt + 11'd1;
    assign h_cur = hedge ? '0 : h_inc;
    assign v_cur = vedge ? '0 : (hedge ? v_inc : v_cnt);
    assign h_sat = (h_cur == '1);

    assign line_bad     = hedge && (h_inc != ref_line);
    assign frame_bad    = vedge && (v_inc != ref_frame);
    assign chk_line_bad = hedge && rl_ok && (h_inc != ref_line);

    // Position counters and the sync-edge measurements.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_period <= '0;
            frame_lines <= '0;
        end else begin
            h_cnt <= h_cur;
            v_cnt <= v_cur;
            if (hedge) line_period <= h_inc;
            if (vedge) frame_lines <= v_inc;
        end
    end

    // Lock FSM state and the reference measurements it compares against.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= SEARCH;
            ref_line  <= '0;
            ref_frame <= '0;
            rl_ok     <= 1'b0;
            rf_ok     <= 1'b0;
            line_mis  <= 1'b0;
            good_cnt  <= '0;
        end else begin
            state     <= state_nx;
            ref_line  <= ref_line_nx;
            ref_frame <= ref_frame_nx;
            rl_ok     <= rl_ok_nx;
            rf_ok     <= rf_ok_nx;
            line_mis  <= line_mis_nx;
            good_cnt  <= good_nx;
        end
    end

    // Next-state: SEARCH waits for a frame boundary, CHECK counts matching frames, LOCKED drops on any deviation.
    always_comb begin
        state_nx     = state;
        ref_line_nx  = ref_line;
        ref_frame_nx = ref_frame;
        rl_ok_nx     = rl_ok;
        rf_ok_nx     = rf_ok;
        line_mis_nx  = line_mis;
        good_nx      = good_cnt;
        case (state)
            SEARCH: begin
                if (vedge) begin
                    state_nx    = CHECK;
                    rl_ok_nx    = 1'b0;
                    rf_ok_nx    = 1'b0;
                    line_mis_nx = 1'b0;
                    good_nx     = '0;
                end
            end
            CHECK: begin
                if (h_sat) begin
                    state_nx = SEARCH;
                end else begin
                    if (hedge) begin
                        if (!rl_ok) begin
                            ref_line_nx = h_inc;
                            rl_ok_nx    = 1'b1;
                        end else if (chk_line_bad) begin
                            ref_line_nx = h_inc;
                            good_nx     = '0;
                        end
                    end
                    if (vedge) begin
                        if (!rf_ok) begin
                            ref_frame_nx = v_inc;
                            rf_ok_nx     = 1'b1;
                        end else if ((v_inc == ref_frame) && !line_mis && !chk_line_bad) begin
                            good_nx = good_cnt + GW'(1);
                        end else begin
                            ref_frame_nx = v_inc;
                            good_nx      = '0;
                        end
                        line_mis_nx = 1'b0;
                    end else if (chk_line_bad) begin
                        line_mis_nx = 1'b1;
                    end
                    if (good_nx == GW'(LOCK_FRAMES)) state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (h_sat || line_bad || frame_bad) state_nx = SEARCH;
            end
            default: state_nx = SEARCH;
        endcase
    end

    assign locked = (state == LOCKED);

    assign h_act  = (h_cur >= 12'(H_START)) && (h_cur < 12'(H_START + H_ACTIVE));
    assign v_act  = (v_cur >= 11'(V_START)) && (v_cur < 11'(V_START + V_ACTIVE));
    // Gate on the next state so a pixel coinciding with loss of lock is already suppressed.
    assign pix_ok = h_act && v_act && (state_nx == LOCKED);

    // Pixel output register; coordinates and colour hold while no valid pixel is present.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= pix_ok;
            frame_start <= pix_ok && (h_cur == 12'(H_START)) && (v_cur == 11'(V_START));
            if (pix_ok) begin
                pix_x   <= 10'(h_cur - 12'(H_START));
                pix_y   <= 10'(v_cur - 11'(V_START));
                pix_rgb <= rgb_s1;
            end
        end
    end
endmodule
